// File: rtl/spi_flash_reader.sv
// Single-lane SPI flash read engine: issues READ_CMD plus a 24-bit address, then
// streams the returned bytes through a one-entry valid/ready output register.
`timescale 1ns/1ps

module spi_flash_reader #(
  parameter int          CS_HIGH_CYCLES = 2,
  parameter logic [7:0]  READ_CMD       = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] address,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic [7:0]  data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        flash_csn,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  localparam int CSW = $clog2(CS_HIGH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_OUT, SHIFT_IN, CS_HIGH} state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     shreg;
  logic [15:0]     byte_cnt;
  logic [4:0]      bit_cnt;
  logic            phase;
  logic            stall;
  logic [CSW-1:0]  cs_cnt;

  logic accept;
  logic out_free;
  logic bit_end;
  logic byte_done;
  logic deliver;
  logic last_byte;
  logic cs_elapsed;
  logic finish;

  // phase=1 is the sck-high half of a bit; a stalled byte waits with sck low
  assign accept     = (state == IDLE) && start && (length != '0);
  assign out_free   = !data_valid || data_ready;
  assign bit_end    = phase && !stall;
  assign byte_done  = (state == SHIFT_IN) && bit_end && (bit_cnt[2:0] == 3'd7);
  assign deliver    = (state == SHIFT_IN) && (byte_done || stall) && out_free;
  assign last_byte  = deliver && (byte_cnt == 16'd1);
  assign cs_elapsed = (cs_cnt == CSW'(CS_HIGH_CYCLES));
  assign finish     = (state == CS_HIGH) && cs_elapsed && !data_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = SHIFT_OUT;
      SHIFT_OUT: if (bit_end && (bit_cnt == 5'd31)) state_next = SHIFT_IN;
      SHIFT_IN:  if (last_byte) state_next = CS_HIGH;
      CS_HIGH:   if (finish) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      stall      <= 1'b0;
      cs_cnt     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      // A newly completed byte may replace the old one in the cycle it is consumed
      if (deliver) begin
        data       <= stall ? shreg[7:0] : {shreg[6:0], flash_miso};
        data_valid <= 1'b1;
        byte_cnt   <= byte_cnt - 16'd1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= {READ_CMD, address};
            byte_cnt <= length;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            stall    <= 1'b0;
          end
        end
        SHIFT_OUT: begin
          phase <= ~phase;
          if (phase) begin
            shreg   <= {shreg[30:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        SHIFT_IN: begin
          if (stall) begin
            if (out_free) stall <= 1'b0;
          end else begin
            phase <= ~phase;
            if (phase) begin
              shreg   <= {shreg[30:0], flash_miso};
              bit_cnt <= bit_cnt + 5'd1;
              if ((bit_cnt[2:0] == 3'd7) && !out_free) stall <= 1'b1;
            end
          end
          if (last_byte) cs_cnt <= '0;
        end
        CS_HIGH: begin
          if (!cs_elapsed) cs_cnt <= cs_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (state != IDLE) && !finish;
    done       = finish;
    flash_csn  = !((state == SHIFT_OUT) || (state == SHIFT_IN));
    flash_sck  = ((state == SHIFT_OUT) || (state == SHIFT_IN)) && phase;
    flash_mosi = (state == SHIFT_OUT) && shreg[31];
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash model plus a byte scoreboard
// holding expected value and handshake cycle for every returned byte.
`timescale 1ns/1ps

module tb_spi_flash_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] address;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic        flash_csn;
  logic        flash_sck;
  logic        flash_mosi;
  logic        flash_miso = 1'b0;

  typedef struct {
    logic [7:0] value;
    int         cycle;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];

  int cyc        = 0;
  int errors     = 0;
  int checks     = 0;
  int sck_edges  = 0;
  int done_count = 0;

  logic [31:0] cmd     = 32'd0;
  int          bit_idx = 0;

  spi_flash_reader #(.CS_HIGH_CYCLES(2), .READ_CMD(8'h03)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .address    (address),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .flash_csn  (flash_csn),
    .flash_sck  (flash_sck),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h100000: return 8'hAA;
      24'h100001: return 8'h55;
      24'h100002: return 8'h01;
      24'h100003: return 8'hFE;
      24'h000000: return 8'h3C;
      default:    return 8'hFF;
    endcase
  endfunction

  // Flash model: captures command/address on rising sck, drives data on falling sck
  always @(posedge flash_sck or posedge flash_csn) begin
    if (flash_csn) begin
      bit_idx <= 0;
    end else begin
      if (bit_idx < 32) cmd <= {cmd[30:0], flash_mosi};
      bit_idx <= bit_idx + 1;
    end
  end

  always @(negedge flash_sck) begin
    logic [7:0] b;
    int         rel;
    if (flash_csn === 1'b0 && bit_idx >= 32) begin
      rel = bit_idx - 32;
      b = flash_byte(cmd[23:0] + 24'(rel / 8));
      flash_miso <= b[7 - (rel % 8)];
    end
  end

  always @(posedge flash_sck) sck_edges <= sck_edges + 1;

  always @(negedge clk) if (done === 1'b1) done_count <= done_count + 1;

  always @(negedge clk) begin
    if (reset === 1'b0 && data_valid === 1'b1 && data_ready === 1'b1)
      obs_q.push_back('{data, cyc});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)",
             tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] a, input logic [15:0] len,
                               output int t0);
    start   = 1'b1;
    address = a;
    length  = len;
    t0      = cyc;
    tick();
    start   = 1'b0;
  endtask

  task automatic drain(input string tag);
    beat_t o;
    beat_t e;
    checkOutput({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checkOutput({tag, "_data"}, 32'(o.value), 32'(e.value));
      checkOutput({tag, "_cycle"}, 32'(o.cycle), 32'(e.cycle));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0;
    int d0;
    int e0;
    logic stall_bad;

    reset      = 1'b1;
    start      = 1'b0;
    address    = '0;
    length     = '0;
    data_ready = 1'b1;

    tick();
    e0 = sck_edges;
    repeat (3) tick();
    checkOutput("reset_busy",  32'(busy),       32'd0);
    checkOutput("reset_done",  32'(done),       32'd0);
    checkOutput("reset_valid", 32'(data_valid), 32'd0);
    checkOutput("reset_data",  32'(data),       32'd0);
    checkOutput("reset_csn",   32'(flash_csn),  32'd1);
    checkOutput("reset_sck",   32'(flash_sck),  32'd0);
    checkOutput("reset_mosi",  32'(flash_mosi), 32'd0);
    checkOutput("reset_sck_edges", 32'(sck_edges), 32'(e0));
    reset = 1'b0;
    tick();

    // Four-byte read with the consumer always ready
    d0 = done_count;
    applyStimulus(24'h100000, 16'd4, t0);
    exp_q.push_back('{8'hAA, t0 + 81});
    exp_q.push_back('{8'h55, t0 + 97});
    exp_q.push_back('{8'h01, t0 + 113});
    exp_q.push_back('{8'hFE, t0 + 129});
    checkOutput("l4_csn_low", 32'(flash_csn), 32'd0);
    checkOutput("l4_busy",    32'(busy),      32'd1);
    wait_until(t0 + 65);
    checkOutput("l4_mosi_stream", cmd, 32'h03100000);
    wait_until(t0 + 129);
    checkOutput("l4_csn_rise", 32'(flash_csn), 32'd1);
    wait_until(t0 + 130);
    checkOutput("l4_done_early", 32'(done), 32'd0);
    wait_until(t0 + 131);
    checkOutput("l4_done",      32'(done), 32'd1);
    checkOutput("l4_busy_done", 32'(busy), 32'd0);
    tick();
    checkOutput("l4_done_count", 32'(done_count), 32'(d0 + 1));
    drain("l4");

    // Same read with the first byte left unconsumed for 40 cycles
    d0 = done_count;
    applyStimulus(24'h100000, 16'd4, t0);
    exp_q.push_back('{8'hAA, t0 + 121});
    exp_q.push_back('{8'h55, t0 + 122});
    exp_q.push_back('{8'h01, t0 + 138});
    exp_q.push_back('{8'hFE, t0 + 154});
    wait_until(t0 + 81);
    data_ready = 1'b0;
    wait_until(t0 + 97);
    e0 = sck_edges;
    stall_bad = 1'b0;
    while (cyc <= t0 + 120) begin
      if (flash_sck !== 1'b0 || flash_csn !== 1'b0 || data !== 8'hAA || data_valid !== 1'b1)
        stall_bad = 1'b1;
      tick();
    end
    data_ready = 1'b1;
    checkOutput("bp_stall_hold", 32'(stall_bad), 32'd0);
    checkOutput("bp_sck_frozen", 32'(sck_edges), 32'(e0));
    wait_until(t0 + 154);
    checkOutput("bp_csn_rise", 32'(flash_csn), 32'd1);
    wait_until(t0 + 155);
    checkOutput("bp_done_early", 32'(done), 32'd0);
    wait_until(t0 + 156);
    checkOutput("bp_done",      32'(done), 32'd1);
    checkOutput("bp_busy_done", 32'(busy), 32'd0);
    tick();
    checkOutput("bp_done_count", 32'(done_count), 32'(d0 + 1));
    drain("bp");

    // Zero-length request is ignored
    d0 = done_count;
    applyStimulus(24'h100000, 16'd0, t0);
    checkOutput("len0_busy", 32'(busy),      32'd0);
    checkOutput("len0_csn",  32'(flash_csn), 32'd1);
    wait_until(t0 + 6);
    checkOutput("len0_csn_later",   32'(flash_csn),  32'd1);
    checkOutput("len0_done_count",  32'(done_count), 32'(d0));

    // Start pulsed mid-burst has no effect
    d0 = done_count;
    applyStimulus(24'h000000, 16'd1, t0);
    exp_q.push_back('{8'h3C, t0 + 81});
    wait_until(t0 + 10);
    start   = 1'b1;
    address = 24'h100000;
    length  = 16'd4;
    tick();
    start   = 1'b0;
    wait_until(t0 + 65);
    checkOutput("busy_start_cmd", cmd, 32'h03000000);
    wait_until(t0 + 83);
    checkOutput("busy_start_done", 32'(done), 32'd1);
    wait_until(t0 + 100);
    checkOutput("busy_start_done_count", 32'(done_count), 32'(d0 + 1));
    checkOutput("busy_start_idle",       32'(busy),       32'd0);
    drain("busy_start");

    // Reset during the address phase aborts silently
    d0 = done_count;
    applyStimulus(24'h100000, 16'd4, t0);
    wait_until(t0 + 30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_csn",   32'(flash_csn),  32'd1);
    checkOutput("abort_sck",   32'(flash_sck),  32'd0);
    checkOutput("abort_busy",  32'(busy),       32'd0);
    checkOutput("abort_valid", 32'(data_valid), 32'd0);
    wait_until(t0 + 120);
    checkOutput("abort_no_done", 32'(done_count), 32'(d0));
    drain("abort");
    applyStimulus(24'h000000, 16'd1, t0);
    exp_q.push_back('{8'h3C, t0 + 81});
    wait_until(t0 + 83);
    checkOutput("after_abort_done", 32'(done), 32'd1);
    tick();
    drain("after_abort");

    // Last byte held unconsumed: done waits for the handshake
    d0 = done_count;
    applyStimulus(24'h000000, 16'd1, t0);
    exp_q.push_back('{8'h3C, t0 + 91});
    wait_until(t0 + 81);
    data_ready = 1'b0;
    checkOutput("tail_csn",   32'(flash_csn),  32'd1);
    checkOutput("tail_valid", 32'(data_valid), 32'd1);
    wait_until(t0 + 85);
    checkOutput("tail_done_withheld", 32'(done), 32'd0);
    checkOutput("tail_busy_held",     32'(busy), 32'd1);
    wait_until(t0 + 91);
    data_ready = 1'b1;
    checkOutput("tail_done_at_handshake", 32'(done), 32'd0);
    wait_until(t0 + 92);
    checkOutput("tail_done",      32'(done), 32'd1);
    checkOutput("tail_busy_done", 32'(busy), 32'd0);
    tick();
    checkOutput("tail_done_count", 32'(done_count), 32'(d0 + 1));
    drain("tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Single-lane SPI flash read engine that sits directly upstream of the board flash, or of the simulated flash model on the simulator top. It drives flash_csn, flash_sck and flash_mosi, and samples flash_miso. A client requests a burst with an address and byte count. The block issues a standard 0x03 read command with a 24-bit address and streams the returned bytes out through a one-entry valid/ready output register. The bootloader and the CPU flash-copy path are its clients.

## Interface
- CS_HIGH_CYCLES, 2: minimum cycles flash_csn is held high after a burst, before done (≥1).
- READ_CMD, 8'h03: command byte shifted out first.

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  burst request; sampled only while busy=0
- address  in  24  flash byte address, captured on accepted start
- length  in  16  byte count, captured on accepted start; 0 = request ignored
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- data  out  8  received byte
- data_valid  out  1  data holds an unconsumed byte
- data_ready  in  1  consumer accepts data when data_valid&&data_ready
- flash_csn  out  1  chip select, active low
- flash_sck  out  1  SPI clock, mode 0 (idle low)
- flash_mosi  out  1  serial out, MSB first
- flash_miso  in  1  serial in, MSB first

## Operation
- Reset values: busy=0, done=0, data_valid=0, data=0, flash_csn=1, flash_sck=0, flash_mosi=0.
- States: IDLE → SHIFT_OUT → SHIFT_IN → CS_HIGH → IDLE.
- IDLE: on start && length≠0:
  - capture {READ_CMD, address} into a 32-bit shift register;
  - capture length into the byte counter;
  - set busy=1 and go to SHIFT_OUT.
- SHIFT_OUT: shift 32 bits MSB first. Each bit lasts 2 cycles: a low phase (mosi updated, sck=0), then a high phase (sck=1).
- SHIFT_IN: the same 2-cycle bit cadence.
  - flash_miso is sampled into the shift register at the clock edge that ends each high phase.
  - After the 8th bit, the byte moves to data, data_valid=1, and the counter decrements.
- Backpressure stall: if a byte completes while data_valid=1 and data_ready=0:
  - sck stays low and csn stays low;
  - the completed byte is held in the shift register;
  - on the first cycle the output register frees, the byte transfers and shifting resumes.
  - No byte is lost or reordered.
- When the counter reaches 0: csn=1, sck=0, go to CS_HIGH.
- CS_HIGH: lasts CS_HIGH_CYCLES cycles. After that, and once data_valid=0 (last byte consumed):
  - done pulses for 1 cycle;
  - busy=0 in the same cycle;
  - return to IDLE.
- start while busy=1 is ignored. No address arithmetic is done; address wrap is the flash's concern.
- Reset mid-burst: on the next cycle all outputs return to reset values, and no done is issued.

## Timing
- t0 = cycle in which start is accepted.
- csn=0 from t0+1. Bit k (k=0..) has its low phase at t0+1+2k and high phase at t0+2+2k (no stalls).
- The first data byte (bits 32..39) gives data_valid=1 at t0+81. Byte n (no stalls) is valid at t0+81+16n.
- csn rises at t0+81+16(L−1), the same cycle the last byte's data_valid rises.
- With the last byte consumed in time, done=1 at t0+81+16(L−1)+CS_HIGH_CYCLES.
- Total: a 1-byte burst with CS_HIGH_CYCLES=2 has done at t0+83.
- A data handshake takes effect at the clock edge: data_valid may re-assert the next cycle with the following byte if it is already complete.
- A stall adds exactly the stalled cycle count to all subsequent timestamps.
- Earliest next start is accepted the cycle after done.

## Test plan
- Reset: assert reset 4 cycles → all outputs at reset values; flash_sck shows no edges.
- Read of L=4 at 0x100000, data_ready=1, flash image bytes AA 55 01 FE at 0x100000:
  - mosi stream is 03 10 00 00;
  - data sequence is AA,55,01,FE at t0+81/97/113/129;
  - csn=1 at t0+129, done at t0+131, busy=0 at t0+131.
- Backpressure: same read with data_ready=0 for 40 cycles after the first byte →
  - sck frozen low, csn low, second byte held;
  - after release, bytes 55,01,FE follow in order;
  - done is delayed by exactly the stall length.
- Ignored requests:
  - start with length=0 → busy stays 0 and csn stays high;
  - start pulsed during an active burst → no effect on the burst, one done only.
- Reset at t0+30 (address phase) → at t0+31 csn=1, sck=0, busy=0, and no done. A following read of L=1 at 0x000000 returns the correct byte with normal timing.
- Final byte unconsumed: data_ready=0 after the last byte arrives → done withheld until data_ready=1. done and busy=0 occur the cycle after the handshake.
